alu_issue_queue: RTL and testbench

Out-of-order issue queue that drives the integer ALU. It is the initiator side of the ALU operand/opcode interface. It accepts renamed micro-ops from dispatch and holds them until both source operands are available, waking them from the writeback broadcast bus. Each cycle it issues the oldest ready op to the combinational ALU and registers the returned result toward writeback.

---
 rtl/alu_pkg.sv | 52 +++++
 rtl/alu_iq_select.sv | 34 +++
 rtl/alu_issue_queue.sv | 173 +++++++++++++++++
 tb/tb_alu_issue_queue.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the integer ALU and its issue queue: opcode encoding,
// queue entry layout and the operand wakeup helper.
package alu_pkg;

    // Entry field widths; the queue's TAG_W/XLEN parameters must match these.
    localparam int IQ_TAG_W = 6;
    localparam int IQ_XLEN  = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_CTZ  = 4'b1001,
        ALU_CLZ  = 4'b1010,
        ALU_CPOP = 4'b1011,
        ALU_SRA  = 4'b1101
    } alu_op_e;

    typedef struct packed {
        logic                rdy;
        logic [IQ_TAG_W-1:0] tag;
        logic [IQ_XLEN-1:0]  val;
    } iq_src_t;

    typedef struct packed {
        logic                valid;
        alu_op_e             op;
        logic [IQ_TAG_W-1:0] dst_tag;
        iq_src_t             src1;
        iq_src_t             src2;
    } iq_entry_t;

    // Capture a broadcast value into a source that is still waiting on it.
    // Sources that are already ready ignore the broadcast.
    function automatic iq_src_t iq_wake(iq_src_t             s,
                                        logic                wb_valid,
                                        logic [IQ_TAG_W-1:0] wb_tag,
                                        logic [IQ_XLEN-1:0]  wb_data);
        iq_wake = s;
        if (!s.rdy && wb_valid && (s.tag == wb_tag)) begin
            iq_wake.rdy = 1'b1;
            iq_wake.val = wb_data;
        end
    endfunction

endpackage

// File: rtl/alu_iq_select.sv
// Oldest-ready picker: grants the eligible entry with the smallest age.
// Ages of valid entries are unique, so at most one grant bit is set.
module alu_iq_select
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AGE_W = 2
) (
    input  logic [DEPTH-1:0]            elig_i,
    input  logic [DEPTH-1:0][AGE_W-1:0] age_i,
    output logic [DEPTH-1:0]            grant_o,
    output logic                        any_grant_o
);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pick
            logic older_found;

            // Grant this entry when it is eligible and no eligible entry is older.
            always_comb begin
                older_found = 1'b0;
                for (int j = 0; j < DEPTH; j++) begin
                    if ((j != gi) && elig_i[j] && (age_i[j] < age_i[gi])) begin
                        older_found = 1'b1;
                    end
                end
                grant_o[gi] = elig_i[gi] && !older_found;
            end
        end
    endgenerate

    assign any_grant_o = |elig_i;

endmodule

// File: rtl/alu_issue_queue.sv
// Out-of-order issue queue feeding the combinational integer ALU. Ops wait
// until both sources are ready (woken by the writeback broadcast); each cycle
// the oldest ready op is issued and its ALU result registered toward writeback.
// Age is a relative rank: 0 is the oldest valid entry, and entries younger
// than an issued one shift down by one so dispatch order is preserved.
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = IQ_TAG_W,
    parameter int XLEN  = IQ_XLEN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       disp_valid_i,
    output logic                       disp_ready_o,
    input  logic [3:0]                 disp_op_i,
    input  logic [TAG_W-1:0]           disp_dst_tag_i,
    input  logic                       disp_src1_rdy_i,
    input  logic                       disp_src2_rdy_i,
    input  logic [TAG_W-1:0]           disp_src1_tag_i,
    input  logic [TAG_W-1:0]           disp_src2_tag_i,
    input  logic [XLEN-1:0]            disp_src1_val_i,
    input  logic [XLEN-1:0]            disp_src2_val_i,
    input  logic                       wb_valid_i,
    input  logic [TAG_W-1:0]           wb_tag_i,
    input  logic [XLEN-1:0]            wb_data_i,
    output logic [3:0]                 alu_op_o,
    output logic [XLEN-1:0]            alu_a_o,
    output logic [XLEN-1:0]            alu_b_o,
    input  logic [XLEN-1:0]            alu_result_i,
    output logic                       res_valid_o,
    output logic [TAG_W-1:0]           res_tag_o,
    output logic [XLEN-1:0]            res_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AGE_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    iq_entry_t               ent_reg [DEPTH];
    logic [AGE_W-1:0]        age_reg [DEPTH];
    logic [CNT_W-1:0]        count_reg;
    logic                    res_valid_reg;
    logic [TAG_W-1:0]        res_tag_reg;
    logic [XLEN-1:0]         res_data_reg;

    logic [DEPTH-1:0]            elig;
    logic [DEPTH-1:0][AGE_W-1:0] age_vec;
    logic [DEPTH-1:0]            grant;
    logic                        issue;
    logic                        disp_fire;
    logic [3:0]                  iss_op;
    logic [XLEN-1:0]             iss_a;
    logic [XLEN-1:0]             iss_b;
    logic [TAG_W-1:0]            iss_tag;
    logic [AGE_W-1:0]            iss_age;
    logic [AGE_W-1:0]            alloc_idx;
    iq_entry_t                   new_ent;
    logic [AGE_W-1:0]            new_age;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_elig
            assign elig[gi]    = ent_reg[gi].valid && ent_reg[gi].src1.rdy && ent_reg[gi].src2.rdy;
            assign age_vec[gi] = age_reg[gi];
        end
    endgenerate

    alu_iq_select #(
        .DEPTH (DEPTH),
        .AGE_W (AGE_W)
    ) u_select (
        .elig_i      (elig),
        .age_i       (age_vec),
        .grant_o     (grant),
        .any_grant_o (issue)
    );

    assign disp_ready_o = (count_reg < CNT_W'(DEPTH));
    assign disp_fire    = disp_valid_i && disp_ready_o;

    // One-hot mux of the granted entry; all zero when nothing is eligible.
    always_comb begin
        iss_op  = '0;
        iss_a   = '0;
        iss_b   = '0;
        iss_tag = '0;
        iss_age = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                iss_op  = iss_op  | ent_reg[i].op;
                iss_a   = iss_a   | ent_reg[i].src1.val;
                iss_b   = iss_b   | ent_reg[i].src2.val;
                iss_tag = iss_tag | ent_reg[i].dst_tag;
                iss_age = iss_age | age_reg[i];
            end
        end
    end

    // Lowest-index free slot, judged on registered state only.
    always_comb begin
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_reg[i].valid) begin
                alloc_idx = AGE_W'(i);
            end
        end
    end

    // Incoming op, with sources woken by a same-cycle broadcast. It becomes
    // the youngest entry after any concurrent issue has been removed.
    always_comb begin
        new_ent.valid    = 1'b1;
        new_ent.op       = alu_op_e'(disp_op_i);
        new_ent.dst_tag  = disp_dst_tag_i;
        new_ent.src1     = iq_wake('{rdy: disp_src1_rdy_i, tag: disp_src1_tag_i, val: disp_src1_val_i},
                                   wb_valid_i, wb_tag_i, wb_data_i);
        new_ent.src2     = iq_wake('{rdy: disp_src2_rdy_i, tag: disp_src2_tag_i, val: disp_src2_val_i},
                                   wb_valid_i, wb_tag_i, wb_data_i);
        new_age          = AGE_W'(count_reg - CNT_W'(issue));
    end

    // Entry state, occupancy and registered result; flush overrides everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_reg[i] <= '0;
                age_reg[i] <= '0;
            end
            count_reg     <= '0;
            res_valid_reg <= 1'b0;
            res_tag_reg   <= '0;
            res_data_reg  <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_reg[i].valid <= 1'b0;
            end
            count_reg     <= '0;
            res_valid_reg <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (disp_fire && (alloc_idx == AGE_W'(i))) begin
                    ent_reg[i] <= new_ent;
                    age_reg[i] <= new_age;
                end else if (issue && grant[i]) begin
                    ent_reg[i].valid <= 1'b0;
                end else if (ent_reg[i].valid) begin
                    ent_reg[i].src1 <= iq_wake(ent_reg[i].src1, wb_valid_i, wb_tag_i, wb_data_i);
                    ent_reg[i].src2 <= iq_wake(ent_reg[i].src2, wb_valid_i, wb_tag_i, wb_data_i);
                    if (issue && (age_reg[i] > iss_age)) begin
                        age_reg[i] <= age_reg[i] - AGE_W'(1);
                    end
                end
            end
            count_reg     <= count_reg + CNT_W'(disp_fire) - CNT_W'(issue);
            res_valid_reg <= issue;
            if (issue) begin
                res_tag_reg  <= iss_tag;
                res_data_reg <= alu_result_i;
            end
        end
    end

    assign alu_op_o    = iss_op;
    assign alu_a_o     = iss_a;
    assign alu_b_o     = iss_b;
    assign res_valid_o = res_valid_reg;
    assign res_tag_o   = res_tag_reg;
    assign res_data_o  = res_data_reg;
    assign count_o     = count_reg;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue. Expected results are queued when the
// stimulus is applied; a monitor pops and compares each registered result.
module tb_alu_issue_queue;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic        disp_valid_i = 1'b0;
    logic        disp_ready_o;
    logic [3:0]  disp_op_i = '0;
    logic [5:0]  disp_dst_tag_i = '0;
    logic        disp_src1_rdy_i = 1'b0;
    logic        disp_src2_rdy_i = 1'b0;
    logic [5:0]  disp_src1_tag_i = '0;
    logic [5:0]  disp_src2_tag_i = '0;
    logic [31:0] disp_src1_val_i = '0;
    logic [31:0] disp_src2_val_i = '0;
    logic        wb_valid_i = 1'b0;
    logic [5:0]  wb_tag_i = '0;
    logic [31:0] wb_data_i = '0;
    logic [3:0]  alu_op_o;
    logic [31:0] alu_a_o;
    logic [31:0] alu_b_o;
    logic [31:0] alu_result_i;
    logic        res_valid_o;
    logic [5:0]  res_tag_o;
    logic [31:0] res_data_o;
    logic [2:0]  count_o;

    typedef struct {
        logic [5:0]  tag;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Reference ALU sitting on the other side of the operand interface.
    function automatic logic [31:0] alu_model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            4'b0000: return a + b;
            4'b0001: return a << b[4:0];
            4'b0010: return {31'b0, $signed(a) < $signed(b)};
            4'b0011: return {31'b0, a < b};
            4'b0100: return a ^ b;
            4'b0101: return a >> b[4:0];
            4'b0110: return a | b;
            4'b0111: return a & b;
            4'b1000: return a - b;
            4'b1011: return 32'($countones(a));
            4'b1101: return $signed(a) >>> b[4:0];
            default: return 32'h0;
        endcase
    endfunction

    assign alu_result_i = alu_model(alu_op_o, alu_a_o, alu_b_o);

    alu_issue_queue #(
        .DEPTH (4),
        .TAG_W (6),
        .XLEN  (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (flush_i),
        .disp_valid_i    (disp_valid_i),
        .disp_ready_o    (disp_ready_o),
        .disp_op_i       (disp_op_i),
        .disp_dst_tag_i  (disp_dst_tag_i),
        .disp_src1_rdy_i (disp_src1_rdy_i),
        .disp_src2_rdy_i (disp_src2_rdy_i),
        .disp_src1_tag_i (disp_src1_tag_i),
        .disp_src2_tag_i (disp_src2_tag_i),
        .disp_src1_val_i (disp_src1_val_i),
        .disp_src2_val_i (disp_src2_val_i),
        .wb_valid_i      (wb_valid_i),
        .wb_tag_i        (wb_tag_i),
        .wb_data_i       (wb_data_i),
        .alu_op_o        (alu_op_o),
        .alu_a_o         (alu_a_o),
        .alu_b_o         (alu_b_o),
        .alu_result_i    (alu_result_i),
        .res_valid_o     (res_valid_o),
        .res_tag_o       (res_tag_o),
        .res_data_o      (res_data_o),
        .count_o         (count_o)
    );

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic push(logic [5:0] tag, logic [31:0] data);
        exp_t e;
        e.tag  = tag;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Pops one expected result for every cycle the DUT presents one.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && res_valid_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got tag=%0d data=%0h expected none", res_tag_o, res_data_o);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("result_tag%0d", e.tag), {26'b0, res_tag_o, res_data_o}, {26'b0, e.tag, e.data});
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle();
        disp_valid_i = 1'b0;
        wb_valid_i   = 1'b0;
        flush_i      = 1'b0;
    endtask

    task automatic disp(logic [3:0] op, logic [5:0] dst,
                        logic r1, logic [5:0] t1, logic [31:0] v1,
                        logic r2, logic [5:0] t2, logic [31:0] v2);
        disp_valid_i    = 1'b1;
        disp_op_i       = op;
        disp_dst_tag_i  = dst;
        disp_src1_rdy_i = r1;
        disp_src1_tag_i = t1;
        disp_src1_val_i = v1;
        disp_src2_rdy_i = r2;
        disp_src2_tag_i = t2;
        disp_src2_val_i = v2;
    endtask

    task automatic bcast(logic [5:0] tag, logic [31:0] data);
        wb_valid_i = 1'b1;
        wb_tag_i   = tag;
        wb_data_i  = data;
    endtask

    logic [3:0]  fill_op  [4];
    logic [31:0] fill_b   [4];
    logic [31:0] fill_res [4];

    initial begin
        fork
            monitor();
        join_none

        // Reset state
        sample();
        check("rst_disp_ready", 64'(disp_ready_o), 64'd1);
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_res", {31'b0, res_valid_o, res_tag_o, res_data_o}, 64'd0);
        check("rst_alu", {28'b0, alu_op_o, alu_a_o}, 64'd0);
        step();
        rst = 1'b0;
        step();

        // ADD with both sources ready: issue next cycle, result the one after
        disp(ALU_ADD, 6'd3, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd7);
        push(6'd3, 32'd12);
        step();
        idle();
        sample();
        check("t1_op", 64'(alu_op_o), 64'(ALU_ADD));
        check("t1_a", 64'(alu_a_o), 64'd5);
        check("t1_b", 64'(alu_b_o), 64'd7);
        check("t1_count", 64'(count_o), 64'd1);
        step();
        step();

        // SUB waiting on tag 9: no issue until the cycle after the wakeup
        disp(ALU_SUB, 6'd4, 1'b1, 6'd0, 32'd10, 1'b0, 6'd9, 32'd0);
        push(6'd4, 32'd6);
        step();
        idle();
        sample();
        check("t2_wait_a", 64'(alu_a_o), 64'd0);
        step();
        bcast(6'd9, 32'd4);
        sample();
        check("t2_wake_cycle_a", 64'(alu_a_o), 64'd0);
        step();
        idle();
        sample();
        check("t2_issue", {28'b0, alu_op_o, alu_a_o}, {28'b0, 4'(ALU_SUB), 32'd10});
        check("t2_issue_b", 64'(alu_b_o), 64'd4);
        step();
        step();

        // Fill the queue with ops waiting on tag 20, then wake them all
        fill_op[0] = ALU_ADD; fill_b[0] = 32'd1;   fill_res[0] = 32'd101;
        fill_op[1] = ALU_SUB; fill_b[1] = 32'd1;   fill_res[1] = 32'd99;
        fill_op[2] = ALU_XOR; fill_b[2] = 32'hFF;  fill_res[2] = 32'd155;
        fill_op[3] = ALU_OR;  fill_b[3] = 32'd3;   fill_res[3] = 32'd103;
        for (int k = 0; k < 4; k++) begin
            disp(fill_op[k], 6'(10 + k), 1'b0, 6'd20, 32'd0, 1'b1, 6'd0, fill_b[k]);
            push(6'(10 + k), fill_res[k]);
            step();
        end
        idle();
        bcast(6'd20, 32'd100);
        sample();
        check("t3_full_ready", 64'(disp_ready_o), 64'd0);
        check("t3_full_count", 64'(count_o), 64'd4);
        step();
        idle();
        sample();
        check("t3_issue_cycle_ready", 64'(disp_ready_o), 64'd0);
        check("t3_first_op", 64'(alu_op_o), 64'(ALU_ADD));
        step();
        sample();
        check("t3_after_issue_ready", 64'(disp_ready_o), 64'd1);
        check("t3_after_issue_count", 64'(count_o), 64'd3);
        for (int k = 0; k < 5; k++) step();

        // CPOP whose src2 is installed ready by a same-cycle broadcast
        disp(ALU_CPOP, 6'd5, 1'b1, 6'd0, 32'h80000000, 1'b0, 6'd12, 32'd0);
        bcast(6'd12, 32'h80000000);
        push(6'd5, 32'd1);
        step();
        idle();
        sample();
        check("t4_op", 64'(alu_op_o), 64'(ALU_CPOP));
        check("t4_b", 64'(alu_b_o), 64'h80000000);
        step();
        step();

        // Older op in the higher slot index issues before the younger one
        disp(ALU_ADD, 6'd20, 1'b0, 6'd30, 32'd0, 1'b1, 6'd0, 32'd1);
        push(6'd20, 32'd6);
        step();
        disp(ALU_ADD, 6'd21, 1'b1, 6'd0, 32'd2, 1'b0, 6'd31, 32'd0);
        push(6'd21, 32'd10);
        step();
        idle();
        bcast(6'd30, 32'd5);
        step();
        idle();
        sample();
        check("t5_first_a", 64'(alu_a_o), 64'd5);
        step();
        disp(ALU_SUB, 6'd22, 1'b1, 6'd0, 32'd50, 1'b0, 6'd31, 32'd0);
        push(6'd22, 32'd42);
        step();
        idle();
        bcast(6'd31, 32'd8);
        step();
        idle();
        sample();
        check("t5_older_first_a", 64'(alu_a_o), 64'd2);
        step();
        sample();
        check("t5_younger_second_a", 64'(alu_a_o), 64'd50);
        step();
        step();
        step();

        // Flush with three waiting ops and one op issuing
        for (int k = 0; k < 3; k++) begin
            disp(ALU_ADD, 6'(30 + k), 1'b0, 6'd40, 32'd0, 1'b1, 6'd0, 32'd1);
            step();
        end
        disp(ALU_ADD, 6'd33, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd1);
        step();
        idle();
        flush_i = 1'b1;
        sample();
        check("t6_issuing_a", 64'(alu_a_o), 64'd1);
        step();
        idle();
        sample();
        check("t6_flush_count", 64'(count_o), 64'd0);
        check("t6_flush_res_valid", 64'(res_valid_o), 64'd0);
        check("t6_flush_ready", 64'(disp_ready_o), 64'd1);
        bcast(6'd40, 32'd9);
        step();
        idle();
        sample();
        check("t6_no_stale_issue", 64'(alu_a_o), 64'd0);
        step();

        // Asynchronous reset in the middle of an issue cycle
        disp(ALU_ADD, 6'd26, 1'b1, 6'd0, 32'd3, 1'b1, 6'd0, 32'd4);
        step();
        idle();
        #1;
        check("t7_pre_rst_a", 64'(alu_a_o), 64'd3);
        check("t7_pre_rst_tag", 64'(res_tag_o), 64'd22);
        #1;
        rst = 1'b1;
        #1;
        check("t7_rst_alu", {28'b0, alu_op_o, alu_a_o}, 64'd0);
        check("t7_rst_b", 64'(alu_b_o), 64'd0);
        check("t7_rst_count", 64'(count_o), 64'd0);
        check("t7_rst_res", {31'b0, res_valid_o, res_tag_o, res_data_o}, 64'd0);
        check("t7_rst_ready", 64'(disp_ready_o), 64'd1);
        step();
        step();
        rst = 1'b0;
        step();
        step();

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
